// File: rtl/ps2_led_command_sender.sv
// PS/2 Set-LEDs command sequencer: sends 0xED plus an LED byte and waits for 0xFA after each.
// It retries on 0xFE or on timeout. Optional PS2_INIT_RESET_EN sends 0xFF after reset and waits for BAT 0xAA.
module ps2_led_command_sender #(
  parameter int unsigned ACK_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [2:0] ledState,
  input  logic       updateRequest,
  output logic [7:0] commandToSend,
  output logic       sendCommand,
  input  logic       commandWasSent,
  input  logic       errorCommunicationTimedOut,
  input  logic [7:0] recievedData,
  input  logic       recievedNewData,
  output logic       busy,
  output logic       suppressRx,
  output logic [2:0] appliedLedState,
  output logic       updateDone,
  output logic       updateFailed
);

`ifdef PS2_INIT_RESET_EN
  localparam int unsigned ST_W     = 4;
  localparam int unsigned TMO_SPAN = ACK_TIMEOUT_CYCLES * 25;
`else
  localparam int unsigned ST_W     = 3;
  localparam int unsigned TMO_SPAN = ACK_TIMEOUT_CYCLES;
`endif
  localparam int unsigned TW = (TMO_SPAN > 1) ? $clog2(TMO_SPAN) : 1;
  localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TW-1:0] ACK_LOAD  = TW'(ACK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  typedef enum logic [ST_W-1:0] {
    ST_IDLE, ST_SEND_CMD, ST_WAIT_SENT_CMD, ST_WAIT_ACK_CMD,
    ST_SEND_DATA, ST_WAIT_SENT_DATA, ST_WAIT_ACK_DATA
`ifdef PS2_INIT_RESET_EN
    , ST_INIT, ST_SEND_RST, ST_WAIT_SENT_RST, ST_WAIT_ACK_RST, ST_WAIT_BAT
`endif
  } state_t;

  state_t        r_state, w_next_state, w_retry_tgt;
  logic          r_pending;
  logic [2:0]    r_led_state;
  logic [RW-1:0] r_retry;
  logic [TW-1:0] r_tmo;

  logic w_ack, w_resend, w_tmo_zero, w_retry_ok, w_retry_req, w_bat_fail;
  logic w_tmo_load, w_retry_clr;
  logic       w_send_d, w_busy_d, w_supp_d, w_done_d, w_failed_d;
  logic [7:0] w_cmd_d;
  logic [2:0] w_applied_d;

  assign w_ack      = recievedNewData && (recievedData == 8'hFA);
  assign w_resend   = recievedNewData && (recievedData == 8'hFE);
  assign w_tmo_zero = (r_tmo == '0);
  assign w_retry_ok = (r_retry < RETRY_MAX);

  // State register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
`ifdef PS2_INIT_RESET_EN
      r_state <= ST_INIT;
`else
      r_state <= ST_IDLE;
`endif
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; every retry decision funnels through w_retry_req
  always_comb begin
    w_next_state = r_state;
    w_retry_req  = 1'b0;
    w_retry_tgt  = ST_IDLE;
    w_bat_fail   = 1'b0;
    case (r_state)
      ST_IDLE:          if (r_pending) w_next_state = ST_SEND_CMD;
      ST_SEND_CMD:      w_next_state = ST_WAIT_SENT_CMD;
      ST_WAIT_SENT_CMD: begin
        w_retry_tgt = ST_SEND_CMD;
        if (errorCommunicationTimedOut) w_retry_req = 1'b1;
        else if (commandWasSent)        w_next_state = ST_WAIT_ACK_CMD;
      end
      ST_WAIT_ACK_CMD: begin
        w_retry_tgt = ST_SEND_CMD;
        if (w_ack)                       w_next_state = ST_SEND_DATA;
        else if (w_resend || w_tmo_zero) w_retry_req = 1'b1;
      end
      ST_SEND_DATA:      w_next_state = ST_WAIT_SENT_DATA;
      ST_WAIT_SENT_DATA: begin
        w_retry_tgt = ST_SEND_DATA;
        if (errorCommunicationTimedOut) w_retry_req = 1'b1;
        else if (commandWasSent)        w_next_state = ST_WAIT_ACK_DATA;
      end
      ST_WAIT_ACK_DATA: begin
        w_retry_tgt = ST_SEND_DATA;
        if (w_ack)                       w_next_state = ST_IDLE;
        else if (w_resend || w_tmo_zero) w_retry_req = 1'b1;
      end
`ifdef PS2_INIT_RESET_EN
      ST_INIT:          w_next_state = ST_SEND_RST;
      ST_SEND_RST:      w_next_state = ST_WAIT_SENT_RST;
      ST_WAIT_SENT_RST: begin
        w_retry_tgt = ST_SEND_RST;
        if (errorCommunicationTimedOut) w_retry_req = 1'b1;
        else if (commandWasSent)        w_next_state = ST_WAIT_ACK_RST;
      end
      ST_WAIT_ACK_RST: begin
        w_retry_tgt = ST_SEND_RST;
        if (w_ack)                       w_next_state = ST_WAIT_BAT;
        else if (w_resend || w_tmo_zero) w_retry_req = 1'b1;
      end
      ST_WAIT_BAT: begin
        if (recievedNewData && (recievedData == 8'hAA)) w_next_state = ST_IDLE;
        else if (w_tmo_zero) begin
          w_bat_fail   = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
`endif
      default: w_next_state = ST_IDLE;
    endcase
    if (w_retry_req) w_next_state = w_retry_ok ? w_retry_tgt : ST_IDLE;
  end

  // Output next-values, registered below so every output is a flop
  always_comb begin
    w_send_d    = 1'b0;
    w_cmd_d     = commandToSend;
    w_busy_d    = (w_next_state != ST_IDLE);
    w_supp_d    = 1'b0;
    w_applied_d = appliedLedState;
    w_done_d    = 1'b0;
    w_failed_d  = (w_retry_req && !w_retry_ok) || w_bat_fail;
    case (w_next_state)
      ST_SEND_CMD: begin
        w_send_d = 1'b1;
        w_cmd_d  = 8'hED;
      end
      ST_SEND_DATA: begin
        w_send_d = 1'b1;
        w_cmd_d  = {5'b0, r_led_state};
      end
      ST_WAIT_ACK_CMD, ST_WAIT_ACK_DATA: w_supp_d = 1'b1;
`ifdef PS2_INIT_RESET_EN
      ST_SEND_RST: begin
        w_send_d = 1'b1;
        w_cmd_d  = 8'hFF;
        w_supp_d = 1'b1;
      end
      ST_INIT, ST_WAIT_SENT_RST, ST_WAIT_ACK_RST, ST_WAIT_BAT: w_supp_d = 1'b1;
`endif
      default: ;
    endcase
    if ((r_state == ST_WAIT_ACK_DATA) && w_ack) begin
      w_done_d    = 1'b1;
      w_applied_d = r_led_state;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      commandToSend   <= 8'h00;
      sendCommand     <= 1'b0;
      busy            <= 1'b0;
      suppressRx      <= 1'b0;
      appliedLedState <= 3'b000;
      updateDone      <= 1'b0;
      updateFailed    <= 1'b0;
    end else begin
      commandToSend   <= w_cmd_d;
      sendCommand     <= w_send_d;
      busy            <= w_busy_d;
      suppressRx      <= w_supp_d;
      appliedLedState <= w_applied_d;
      updateDone      <= w_done_d;
      updateFailed    <= w_failed_d;
    end
  end

  assign w_tmo_load = (r_state != w_next_state) &&
                      ((w_next_state == ST_WAIT_ACK_CMD) || (w_next_state == ST_WAIT_ACK_DATA)
`ifdef PS2_INIT_RESET_EN
                       || (w_next_state == ST_WAIT_ACK_RST)
`endif
                      );
  assign w_retry_clr = (r_state == ST_IDLE) || ((r_state == ST_WAIT_ACK_CMD) && w_ack);

  // Pending request, latched LED byte, retry count and ACK timer
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_pending   <= 1'b0;
      r_led_state <= 3'b000;
      r_retry     <= '0;
      r_tmo       <= '0;
    end else begin
      r_pending <= updateRequest | (r_pending & (r_state != ST_IDLE));
      if ((r_state == ST_IDLE) && r_pending) r_led_state <= ledState;
      if (w_retry_req && w_retry_ok) r_retry <= r_retry + RW'(1);
      else if (w_retry_clr)          r_retry <= '0;
      if (w_tmo_load) r_tmo <= ACK_LOAD;
`ifdef PS2_INIT_RESET_EN
      else if ((r_state == ST_WAIT_ACK_RST) && (w_next_state == ST_WAIT_BAT))
        r_tmo <= TW'(TMO_SPAN - 1);
`endif
      else if (!w_tmo_zero) r_tmo <= r_tmo - TW'(1);
    end
  end

endmodule

// File: doc/ps2_led_command_sender.md
Name: ps2_led_command_sender

Overview:
Host-to-keyboard command sequencer on the PS/2 link. It drives the transmit side of the PS2_Controller (commandToSend, sendCommand) and consumes its completion, error and receive outputs. It issues the two-byte Set-LEDs command (0xED followed by an LED byte), waits for the 0xFA acknowledge after each byte, and retries on 0xFE resend or on timeout. It sits beside the scan-code decoder and tells that decoder when to ignore acknowledge bytes.

Parameters:
ACK_TIMEOUT_CYCLES, 1000000, CLOCK_50 cycles to wait for an ACK after a byte is sent (20 ms).
MAX_RETRIES, 3, resend attempts per byte before the transaction is abandoned.

Ports:
CLOCK_50  input  1  system clock, 50 MHz
resetn  input  1  asynchronous, active-low reset
ledState  input  3  requested LEDs: bit2 Caps, bit1 Num, bit0 Scroll
updateRequest  input  1  one-cycle pulse requesting an LED update
commandToSend  output  8  byte presented to the PS2_Controller
sendCommand  output  1  one-cycle pulse that starts transmission of commandToSend
commandWasSent  input  1  pulse from the controller: byte transmitted
errorCommunicationTimedOut  input  1  pulse from the controller: transmit failed
recievedData  input  8  byte received from the keyboard
recievedNewData  input  1  one-cycle strobe marking recievedData as valid
busy  output  1  high whenever the FSM is not in IDLE
suppressRx  output  1  high in the WAIT_ACK states; the scan-code decoder ignores bytes while it is high
appliedLedState  output  3  last LED byte the keyboard acknowledged
updateDone  output  1  one-cycle pulse on a successful transaction
updateFailed  output  1  one-cycle pulse when retries are exhausted

Behaviour:
- Reset values: FSM in IDLE; all outputs 0 (commandToSend 8'h00, appliedLedState 3'b000); pending flag and counters cleared. Reset takes effect asynchronously at any point, including mid-transaction.
- States: IDLE, SEND_CMD, WAIT_SENT_CMD, WAIT_ACK_CMD, SEND_DATA, WAIT_SENT_DATA, WAIT_ACK_DATA.
- Pending flag:
  - Set by updateRequest in any state.
  - In IDLE with the flag set: clear it, latch ledState into an internal byte {5'b0, ledState}, reset the retry count, go to SEND_CMD.
  - A request arriving during a transaction starts exactly one further transaction afterwards. That transaction samples ledState when it starts.
- SEND_x states:
  - Load commandToSend (8'hED, or the latched LED byte).
  - Assert sendCommand for exactly one cycle, then go to WAIT_SENT_x.
  - commandToSend holds its value until the next SEND_x state.
- WAIT_SENT_x:
  - commandWasSent → WAIT_ACK_x; load the timeout counter with ACK_TIMEOUT_CYCLES-1.
  - errorCommunicationTimedOut → retry.
  - If both arrive in the same cycle, the error wins.
- WAIT_ACK_x:
  - Counter decrements every cycle.
  - recievedNewData with 8'hFA: from WAIT_ACK_CMD go to SEND_DATA with the retry count reset; from WAIT_ACK_DATA update appliedLedState, pulse updateDone, go to IDLE.
  - recievedNewData with 8'hFE → retry.
  - Any other byte is ignored; the counter keeps running.
  - Counter reaching 0 with no ACK → retry.
  - An ACK in the same cycle the counter hits 0 counts as the ACK.
- Retry rule:
  - If retry count < MAX_RETRIES: increment it and re-enter the SEND_x state of the same byte.
  - Otherwise: pulse updateFailed, go to IDLE; appliedLedState is unchanged.
  - A failed 0xED is never followed by the data byte.
- suppressRx = 1 exactly in the WAIT_ACK_CMD and WAIT_ACK_DATA states.
- busy is registered and equals (state != IDLE).
- Latency with an instant controller and ACKs: request at cycle N, sendCommand for 0xED at N+2.

Optional Feature:
PS2_INIT_RESET_EN
- Defined: after reset, before IDLE, the FSM sends 8'hFF with the same ACK/retry rules. It then waits up to ACK_TIMEOUT_CYCLES×25 for 8'hAA (BAT pass). busy and suppressRx stay high throughout. Requests arriving meanwhile are pended. A failure pulses updateFailed and then goes to IDLE.
- Undefined: the FSM enters IDLE directly after reset; the extra states and logic are absent.

Test Plan:
- ledState=3'b101, updateRequest pulse; controller returns commandWasSent; keyboard replies 0xFA twice → commandToSend 0xED then 0x05; one sendCommand pulse each; updateDone once; appliedLedState=3'b101.
- 0xFE after the data byte, then 0xFA → data byte 0x05 resent exactly once; updateDone; no second 0xED.
- No ACK ever (ACK_TIMEOUT_CYCLES=100 for sim) → 4 sendCommand pulses of 0xED; updateFailed; appliedLedState unchanged; 0x05 never sent.
- Scan code 0x1C arrives in WAIT_ACK_CMD, then 0xFA → 0x1C ignored; suppressRx=1 throughout the wait; transaction completes.
- Second updateRequest with ledState=3'b010 mid-transaction → first transaction completes; exactly one more starts and sends 0x02.
- resetn low during WAIT_ACK_DATA → all outputs 0 immediately; pending request discarded; no updateDone.
